// File: rtl/not_not_pkg.sv
// Shared definitions for the Not-Not game: state encoding and datapath widths.
package not_not_pkg;

    localparam int unsigned COLOR_W = 4;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_DRAW      = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_PLAY      = 3'd3;
    localparam logic [STATE_W-1:0] ST_JUDGE     = 3'd4;
    localparam logic [STATE_W-1:0] ST_GAME_OVER = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        StIdle     = ST_IDLE,
        StDraw     = ST_DRAW,
        StSettle   = ST_SETTLE,
        StPlay     = ST_PLAY,
        StJudge    = ST_JUDGE,
        StGameOver = ST_GAME_OVER
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Countdown prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the wrap cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CntW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/not_not_round_ctrl.sv
// Round sequencer for the Not-Not game: draws a challenge, runs the countdown,
// judges the submitted switch mask and tracks score and lives.
module not_not_round_ctrl
    import not_not_pkg::*;
#(
    parameter int unsigned DRAW_CYCLES = 7,
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ROUND_TICKS = 5,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               submit,
    input  logic [COLOR_W-1:0] answer,
    input  logic [COLOR_W-1:0] expected,
    output logic               lfsr_enable,
    output logic               round_active,
    output logic [3:0]         time_left,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               last_correct,
    output logic               game_over
);

    localparam int unsigned TimeW = 4;
    localparam int unsigned DrawW = 8;

    state_e             state_q, state_d;
    logic [DrawW-1:0]   draw_cnt_q, draw_cnt_d;
    logic [TimeW-1:0]   time_q, time_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [COLOR_W-1:0] exp_q, exp_d;
    logic               last_q, last_d;
    logic               hit_q, hit_d;
    logic               sub_q;
    logic               lfsr_q, active_q, over_q;
    logic               sub_edge;
    logic               tick;

    assign sub_edge = submit & ~sub_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q == StSettle),
        .enable (state_q == StPlay),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        draw_cnt_d = draw_cnt_q;
        time_d     = time_q;
        score_d    = score_q;
        lives_d    = lives_q;
        exp_d      = exp_q;
        last_d     = last_q;
        hit_d      = hit_q;

        unique case (state_q)
            StIdle, StGameOver: begin
                if (start) begin
                    score_d    = '0;
                    lives_d    = LIVES_W'(LIVES);
                    draw_cnt_d = DrawW'(DRAW_CYCLES - 1);
                    state_d    = StDraw;
                end
            end
            StDraw: begin
                if (draw_cnt_q == '0) begin
                    state_d = StSettle;
                end else begin
                    draw_cnt_d = draw_cnt_q - DrawW'(1);
                end
            end
            StSettle: begin
                exp_d   = expected;
                time_d  = TimeW'(ROUND_TICKS);
                state_d = StPlay;
            end
            StPlay: begin
                if (tick) begin
                    time_d = time_q - TimeW'(1);
                end
                // A submit on the final tick still counts as an answer.
                if (sub_edge) begin
                    hit_d   = (answer == exp_q);
                    state_d = StJudge;
                end else if (tick && time_q == TimeW'(1)) begin
                    hit_d   = 1'b0;
                    state_d = StJudge;
                end
            end
            StJudge: begin
                last_d     = hit_q;
                draw_cnt_d = DrawW'(DRAW_CYCLES - 1);
                if (hit_q) begin
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    state_d = StDraw;
                end else begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = (lives_q == LIVES_W'(1)) ? StGameOver : StDraw;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            draw_cnt_q <= '0;
            time_q     <= '0;
            score_q    <= '0;
            lives_q    <= '0;
            exp_q      <= '0;
            last_q     <= 1'b0;
            hit_q      <= 1'b0;
            sub_q      <= 1'b0;
            lfsr_q     <= 1'b0;
            active_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            draw_cnt_q <= draw_cnt_d;
            time_q     <= time_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            exp_q      <= exp_d;
            last_q     <= last_d;
            hit_q      <= hit_d;
            sub_q      <= submit;
            lfsr_q     <= (state_d == StDraw);
            active_q   <= (state_d == StPlay);
            over_q     <= (state_d == StGameOver);
        end
    end

    assign lfsr_enable  = lfsr_q;
    assign round_active = active_q;
    assign time_left    = time_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign last_correct = last_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_not_not_round_ctrl.sv
// Directed bench for not_not_round_ctrl with TICK_DIV=4, ROUND_TICKS=3, LIVES=3, DRAW_CYCLES=5.
module tb_not_not_round_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic       submit;
    logic [3:0] answer;
    logic [3:0] expected;
    logic       lfsr_enable;
    logic       round_active;
    logic [3:0] time_left;
    logic [7:0] score;
    logic [2:0] lives;
    logic       last_correct;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    not_not_round_ctrl #(
        .DRAW_CYCLES (5),
        .TICK_DIV    (4),
        .ROUND_TICKS (3),
        .LIVES       (3),
        .SCORE_W     (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .submit       (submit),
        .answer       (answer),
        .expected     (expected),
        .lfsr_enable  (lfsr_enable),
        .round_active (round_active),
        .time_left    (time_left),
        .score        (score),
        .lives        (lives),
        .last_correct (last_correct),
        .game_over    (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_play();
        int n = 0;
        while (!round_active && n < 40) begin
            step();
            n++;
        end
        check_eq("play_reached", 32'(round_active), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_lfsr"}, 32'(lfsr_enable), 0);
        check_eq({tag, "_active"}, 32'(round_active), 0);
        check_eq({tag, "_time"}, 32'(time_left), 0);
        check_eq({tag, "_score"}, 32'(score), 0);
        check_eq({tag, "_lives"}, 32'(lives), 0);
        check_eq({tag, "_last"}, 32'(last_correct), 0);
        check_eq({tag, "_over"}, 32'(game_over), 0);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        submit   = 1'b0;
        answer   = 4'b0000;
        expected = 4'b0101;

        step();
        check_idle_outputs("reset");
        reset = 1'b1;
        step();

        // Start: lfsr_enable high for exactly 5 cycles, then SETTLE, then PLAY.
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_lfsr", 32'(lfsr_enable), 1);
        n = 0;
        while (lfsr_enable && n < 20) begin
            n++;
            step();
        end
        check_eq("draw_len", 32'(n), 5);
        check_eq("settle_active", 32'(round_active), 0);
        step();
        check_eq("play_active", 32'(round_active), 1);
        check_eq("play_time", 32'(time_left), 3);
        check_eq("play_lives", 32'(lives), 3);
        check_eq("play_score", 32'(score), 0);

        // Correct answer.
        answer = 4'b0101;
        submit = 1'b1;
        step();
        check_eq("judge_active", 32'(round_active), 0);
        step();
        submit = 1'b0;
        check_eq("hit_last", 32'(last_correct), 1);
        check_eq("hit_score", 32'(score), 1);
        check_eq("hit_lives", 32'(lives), 3);
        check_eq("hit_redraw", 32'(lfsr_enable), 1);

        // Submit edge during DRAW must not queue into the next round.
        step();
        submit = 1'b1;
        step();
        submit = 1'b0;
        wait_play();
        step();
        step();
        check_eq("noqueue_active", 32'(round_active), 1);

        // Wrong answer; a change on expected during PLAY is ignored.
        expected = 4'b1010;
        answer   = 4'b1010;
        submit   = 1'b1;
        step();
        step();
        submit   = 1'b0;
        expected = 4'b0101;
        check_eq("miss_last", 32'(last_correct), 0);
        check_eq("miss_lives", 32'(lives), 2);
        check_eq("miss_score", 32'(score), 1);

        // Timeout: time_left 3,2,1 at 4-cycle spacing, then 0 in JUDGE.
        wait_play();
        for (int i = 0; i < 12; i++) begin
            check_eq($sformatf("tl_%0d", i), 32'(time_left), 32'(3 - i / 4));
            step();
        end
        check_eq("to_active", 32'(round_active), 0);
        check_eq("to_time", 32'(time_left), 0);
        step();
        check_eq("to_last", 32'(last_correct), 0);
        check_eq("to_lives", 32'(lives), 1);
        check_eq("to_score", 32'(score), 1);

        // Submit on the final tick is judged as a submit.
        wait_play();
        for (int i = 0; i < 11; i++) step();
        answer = 4'b0101;
        submit = 1'b1;
        step();
        step();
        submit = 1'b0;
        check_eq("ft_last", 32'(last_correct), 1);
        check_eq("ft_score", 32'(score), 2);
        check_eq("ft_lives", 32'(lives), 1);

        // Third miss ends the game.
        wait_play();
        answer = 4'b0000;
        submit = 1'b1;
        step();
        step();
        submit = 1'b0;
        check_eq("go_over", 32'(game_over), 1);
        check_eq("go_lives", 32'(lives), 0);
        check_eq("go_score", 32'(score), 2);
        check_eq("go_active", 32'(round_active), 0);
        check_eq("go_lfsr", 32'(lfsr_enable), 0);

        // Submit edges in GAME_OVER are ignored.
        step();
        submit = 1'b1;
        step();
        step();
        submit = 1'b0;
        step();
        check_eq("go_hold_over", 32'(game_over), 1);
        check_eq("go_hold_score", 32'(score), 2);
        check_eq("go_hold_active", 32'(round_active), 0);

        // Restart.
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("rs_over", 32'(game_over), 0);
        check_eq("rs_score", 32'(score), 0);
        check_eq("rs_lives", 32'(lives), 3);
        check_eq("rs_lfsr", 32'(lfsr_enable), 1);
        wait_play();
        check_eq("rs_time", 32'(time_left), 3);

        // Asynchronous reset during PLAY clears outputs before the next edge.
        step();
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("areset");
        step();
        reset = 1'b1;
        step();
        step();
        check_eq("post_reset_idle", 32'(lfsr_enable), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
